// File: rtl/alu_pkg.sv
// Definitions shared by the ALU issue stage and the ALU: op codes, RV32I
// opcodes, FSM states and the instruction decode helpers.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WB,
    ST_ILLEGAL
  } state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_imm;
    logic [3:0]  op;
    logic [31:0] imm;
  } dec_t;

  // f7 doubles as imm[11:5] for OP-IMM shifts.
  function automatic logic is_legal(input logic [6:0] f7, input logic [2:0] f3,
                                    input logic [6:0] opcode);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OPC_OP: ok = (f7 == F7_ZERO) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
      OPC_OP_IMM: begin
        case (f3)
          3'b001:  ok = (f7 == F7_ZERO);
          3'b101:  ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
          default: ok = 1'b1;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.rd     = instr[11:7];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.imm    = {{20{instr[31]}}, instr[31:20]};
    d.is_imm = (instr[6:0] == OPC_OP_IMM);
    if (d.is_imm)
      d.op = {(instr[14:12] == 3'b101) && (instr[31:25] == F7_ALT), instr[14:12]};
    else
      d.op = {instr[30], instr[14:12]};
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake (producer -> issue stage) and ALU operand/result bus
// (issue stage -> ALU).
interface instr_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

interface alu_if;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0]  alu_op;
  logic [31:0] alu_rd;

  modport master (output alu_rs1, output alu_rs2, output alu_op, input alu_rd);
  modport slave  (input alu_rs1, input alu_rs2, input alu_op, output alu_rd);
endinterface

// File: rtl/alu.sv
// RV32I integer ALU: result appears ALU_LATENCY clocks after the operands,
// which the issue stage holds stable for that whole time.
module alu
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  alu_bus
);

  logic [31:0] result;
  logic [31:0] pipe_q [ALU_LATENCY];
  logic [31:0] pipe_d [ALU_LATENCY];
  logic [4:0]  shamt;

  assign shamt = alu_bus.alu_rs2[4:0];

  always_comb begin
    result = '0;
    case (alu_bus.alu_op)
      ALU_ADD:  result = alu_bus.alu_rs1 + alu_bus.alu_rs2;
      ALU_SUB:  result = alu_bus.alu_rs1 - alu_bus.alu_rs2;
      ALU_SLL:  result = alu_bus.alu_rs1 << shamt;
      ALU_SLT:  result = {31'b0, $signed(alu_bus.alu_rs1) < $signed(alu_bus.alu_rs2)};
      ALU_SLTU: result = {31'b0, alu_bus.alu_rs1 < alu_bus.alu_rs2};
      ALU_XOR:  result = alu_bus.alu_rs1 ^ alu_bus.alu_rs2;
      ALU_SRL:  result = alu_bus.alu_rs1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(alu_bus.alu_rs1) >>> shamt);
      ALU_OR:   result = alu_bus.alu_rs1 | alu_bus.alu_rs2;
      ALU_AND:  result = alu_bus.alu_rs1 & alu_bus.alu_rs2;
      default:  result = '0;
    endcase
  end

  always_comb begin
    pipe_d[0] = result;
    for (int i = 1; i < ALU_LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ALU_LATENCY; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign alu_bus.alu_rd = pipe_q[ALU_LATENCY-1];

endmodule

// File: rtl/alu_regfile.sv
// 32x32 register file: two combinational operand reads, a debug read and one
// synchronous write port; x0 is hardwired to zero.
module alu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  output logic [31:0] rs1_data,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs2_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // NOTE: every variable in an always_comb gets a default before any branch;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != 5'd0))
      regs_d[wr_addr] = wr_data;
  end

  // NOTE: this memory is reset because software relies on all registers
  // reading zero after reset; a plain RAM macro would not give that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      regs_q <= regs_d;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage: accepts one OP/OP-IMM instruction, presents its
// operands to the ALU, waits ALU_LATENCY cycles and writes the result back.
module alu_issue
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  instr_if.slave      instr_bus,
  alu_if.master       alu_bus,
  output logic        done,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int CNT_W = $clog2(ALU_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wr_en;
  logic             ready;
  logic             in_legal;
  logic [31:0]      rf_rs1, rf_rs2;
  dec_t             dec;

  assign dec      = decode(instr_q);
  assign in_legal = is_legal(instr_bus.instr[31:25], instr_bus.instr[14:12],
                             instr_bus.instr[6:0]);

  alu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (dec.rs1),
    .rs1_data (rf_rs1),
    .rs2_addr (dec.rs2),
    .rs2_data (rf_rs2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_en    (wr_en),
    .wr_addr  (dec.rd),
    .wr_data  (alu_bus.alu_rd)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (instr_bus.instr_valid) begin
          instr_d = instr_bus.instr;
          state_d = in_legal ? ST_ISSUE : ST_ILLEGAL;
        end
      end
      ST_ISSUE: begin
        rs1_d   = rf_rs1;
        rs2_d   = dec.is_imm ? dec.imm : rf_rs2;
        op_d    = dec.op;
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      // Operands stay registered and untouched until the next ISSUE.
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE)
          state_d = ST_WB;
      end
      ST_WB: begin
        wr_en   = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ILLEGAL: begin
        illegal = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_bus.instr_ready = ready;
  assign alu_bus.alu_rs1       = rs1_q;
  assign alu_bus.alu_rs2       = rs2_q;
  assign alu_bus.alu_op        = op_q;

endmodule
